aes_iter_cipher: RTL and testbench
==================================

Name: aes_iter_cipher

Overview:
Iterative AES encryption core, parametrised by key size (128/192/256). It replaces the fully unrolled combinational cipher with one round engine reused across Nr clock cycles. Round keys are expanded one word per cycle into an internal register file and retained, so several blocks can be encrypted under one key. Valid/ready handshakes are used on key input, data input and data output.

Parameters:
KEY_BITS, 128, AES key length; legal values 128/192/256, any other value fails elaboration
NK, KEY_BITS/32, key length in 32-bit words (derived, not overridable)
NR, NK+6, number of rounds (derived: 10/12/14)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
key_in  in  KEY_BITS  cipher key; byte 0 in MSBs, FIPS-197 byte order
key_valid  in  1  key_in valid
key_ready  out  1  core can accept a key
in_data  in  128  plaintext block; byte 0 in MSBs, column-major state mapping
in_valid  in  1  in_data valid
in_ready  out  1  core can accept a block
out_data  out  128  ciphertext block
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data
busy  out  1  high in KEYEXP or ROUND

Behaviour:
- Clocking: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values:
  - FSM state = IDLE; key_loaded = 0.
  - out_valid = 0; out_data = 0; busy = 0.
  - key_ready = 1; in_ready = 0.
  - Round-key file is not reset. It is don't-care until key_loaded = 1.
- FSM states: IDLE, KEYEXP, ROUND, DONE.
- IDLE:
  - key_ready = 1.
  - in_ready = key_loaded.
  - If key_valid and in_valid are both high, the key wins: in_ready is driven 0 whenever key_valid = 1.
- Key accept (key_valid & key_ready):
  - Capture words w[0..NK-1]; clear key_loaded; go to KEYEXP.
- KEYEXP:
  - One word per cycle for i = NK .. 4*(NR+1)-1: w[i] = w[i-NK] ^ t.
  - t = SubWord(RotWord(w[i-1])) ^ Rcon[i/NK] when i mod NK = 0.
  - t = SubWord(w[i-1]) when NK = 8 and i mod NK = 4.
  - t = w[i-1] otherwise.
  - Duration is exactly 40/46/52 cycles (KEY_BITS 128/192/256).
  - After the last word: key_loaded = 1; go to IDLE.
  - Neither key_ready nor in_ready is asserted during KEYEXP.
- Block accept (in_valid & in_ready), at edge T0:
  - state reg = in_data ^ w[0..3]; round = 1; go to ROUND.
- ROUND, at edges T1..T_NR:
  - state = AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), w[4r..4r+3]).
  - MixColumns is skipped when r = NR.
  - After T_NR: out_data = state, out_valid = 1, go to DONE.
  - Latency from accept edge to out_valid high is exactly NR cycles.
- DONE:
  - out_valid and out_data are held stable until out_ready = 1.
  - On out_valid & out_ready: out_valid = 0 next cycle; go to IDLE.
  - out_data keeps its last value after the transfer.
  - There is no same-cycle re-accept. Maximum throughput is one block per NR+2 cycles.
- Round counter: width clog2(NR+1). It never wraps; it is cleared on accept.
- Stray handshakes: key_valid or in_valid asserted in ROUND/DONE/KEYEXP is ignored. The source must hold it until ready.
- Reset mid-operation: returns all outputs to their reset values immediately (asynchronous). Any partial key or block is discarded, and a key must be reloaded before data is accepted.
- The key is retained across blocks until a new key is accepted.

Decomposition:
- Package aes_pkg holds:
  - S-box table and Rcon table.
  - xtime / GF(2^8) multiply functions.
  - 4x4 byte state typedef and 32-bit word typedef.
  - Functions nk_of(KEY_BITS) and nr_of(KEY_BITS).
  - FSM state enum.
- Sub-module aes_round: combinational single round with input final_round. It composes the existing subBytes, shiftRows, mixColumns and addRoundKey blocks.
- KEYEXP word logic stays inline in aes_iter_cipher.

Test Plan:
1. KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, then block 3243f6a8885a308d313198a2e0370734 -> key_ready back high after 40 cycles; out_data = 3925841d02dc09fbdc118597196a0b32 with out_valid exactly 10 cycles after accept.
2. KEY_BITS=128, key 000102…0f, then two blocks 00112233445566778899aabbccddeeff under one key load, with out_ready held 0 for 5 cycles on the first -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a stable while waiting; second block gives the same result.
3. KEY_BITS=192, key 000102…17 and KEY_BITS=256, key 000102…1f, same plaintext -> dda97ca4864cdfe06eaf70a0ec0d7191 and 8ea2b7ca516745bfeafc49904b496089; KEYEXP lasts 46 and 52 cycles, latency 12 and 14.
4. After reset, in_valid=1 with no key loaded -> in_ready stays 0 and no output. Then key_valid and in_valid asserted together -> key accepted first, block accepted only after KEYEXP completes.
5. Assert rst low at round 5 of a block -> out_valid=0, out_data=0, in_ready=0 immediately; after release, reload key and re-run vector 1 -> correct ciphertext.
6. Load new key 000102…0f over an existing key while in IDLE -> in_ready drops for 40 cycles; next ciphertext matches vector 2.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, S-box/Rcon tables and GF(2^8) helpers for the iterative cipher.
package aes_pkg;

    typedef logic [31:0] aesWord;
    // Column c is element [3-c]; inside a column row 0 is the most significant byte.
    typedef logic [3:0][3:0][7:0] aesState;

    typedef enum logic [1:0] {StIdle, StKeyExp, StRound, StDone} aesFsmState;

    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 is never used; round constants start at index 1.
    localparam logic [7:0] RconTable [11] = '{
        8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic int unsigned nk_of(int unsigned keyBits);
        return keyBits / 32;
    endfunction

    function automatic int unsigned nr_of(int unsigned keyBits);
        return keyBits / 32 + 6;
    endfunction

    function automatic logic [7:0] sbox(logic [7:0] x);
        return SboxTable[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gfMul3(logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    function automatic aesWord subWord(aesWord w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic aesWord rotWord(aesWord w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic aesState subBytes(aesState s);
        aesState o;
        for (int c = 0; c < 4; c++) begin
            o[c] = subWord(s[c]);
        end
        return o;
    endfunction

    function automatic aesState shiftRows(aesState s);
        aesState o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[3-c][3-r] = s[3-((c+r)%4)][3-r];
            end
        end
        return o;
    endfunction

    function automatic aesState mixColumns(aesState s);
        aesState o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[c];
            o[c] = {xtime(a0) ^ gfMul3(a1) ^ a2 ^ a3,
                    a0 ^ xtime(a1) ^ gfMul3(a2) ^ a3,
                    a0 ^ a1 ^ xtime(a2) ^ gfMul3(a3),
                    gfMul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic aesState addRoundKey(aesState s, aesState k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round; MixColumns is bypassed on the final round.
module aes_round
    import aes_pkg::*;
(
    input  aesState stateIn,
    input  aesState roundKey,
    input  logic    final_round,
    output aesState stateOut
);

    aesState shifted;
    aesState mixed;

    always_comb begin
        shifted  = shiftRows(subBytes(stateIn));
        mixed    = final_round ? shifted : mixColumns(shifted);
        stateOut = addRoundKey(mixed, roundKey);
    end

endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES encryption core: one round per cycle, key schedule expanded one word
// per cycle into a retained round-key file.
module aes_iter_cipher
    import aes_pkg::*;
#(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [127:0]        in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [127:0]        out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    localparam int unsigned NK   = nk_of(KEY_BITS);
    localparam int unsigned NR   = nr_of(KEY_BITS);
    localparam int unsigned NW   = 4 * (NR + 1);
    localparam int unsigned IdxW = $clog2(NW);
    localparam int unsigned RndW = $clog2(NR + 1);

    if (!(KEY_BITS inside {128, 192, 256})) begin : gBadKeyBits
        $error("aes_iter_cipher: KEY_BITS must be 128, 192 or 256");
    end

    aesFsmState      fsmState;
    logic            keyLoaded, keyReadyQ, inReadyQ, busyQ, outValidQ;
    logic [127:0]    outDataQ;
    aesState         cipherState, roundOut, roundKey, firstKey;
    aesWord          rkFile [NW];
    logic [IdxW-1:0] keyIdx, rkBase;
    logic [2:0]      kMod;
    logic [3:0]      rconIdx;
    logic [RndW-1:0] round;
    aesWord          prevWord, expTemp, newWord;
    logic            keyAccept, blockAccept, lastRound;

    assign key_ready = keyReadyQ;
    // A pending key always takes priority over a pending block.
    assign in_ready  = inReadyQ & ~key_valid;
    assign out_valid = outValidQ;
    assign out_data  = outDataQ;
    assign busy      = busyQ;

    assign keyAccept   = (fsmState == StIdle) && key_valid && keyReadyQ;
    assign blockAccept = (fsmState == StIdle) && in_valid && in_ready;
    assign lastRound   = (round == RndW'(NR));

    always_comb begin
        prevWord = rkFile[keyIdx - IdxW'(1)];
        if (kMod == 3'd0) begin
            expTemp = subWord(rotWord(prevWord)) ^ {RconTable[rconIdx], 24'h000000};
        end else if (NK == 8 && kMod == 3'd4) begin
            expTemp = subWord(prevWord);
        end else begin
            expTemp = prevWord;
        end
        newWord = rkFile[keyIdx - IdxW'(NK)] ^ expTemp;
    end

    always_comb begin
        rkBase = IdxW'({round, 2'b00});
        for (int j = 0; j < 4; j++) begin
            roundKey[3-j] = rkFile[rkBase + IdxW'(j)];
            firstKey[3-j] = rkFile[j];
        end
    end

    aes_round uRound (
        .stateIn    (cipherState),
        .roundKey   (roundKey),
        .final_round(lastRound),
        .stateOut   (roundOut)
    );

    // Round-key storage carries no reset; it is only read once keyLoaded is set.
    always_ff @(posedge clk) begin
        if (keyAccept) begin
            for (int i = 0; i < NK; i++) begin
                rkFile[i] <= key_in[KEY_BITS-1-32*i -: 32];
            end
        end else if (fsmState == StKeyExp) begin
            rkFile[keyIdx] <= newWord;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsmState    <= StIdle;
            keyLoaded   <= 1'b0;
            keyReadyQ   <= 1'b1;
            inReadyQ    <= 1'b0;
            busyQ       <= 1'b0;
            outValidQ   <= 1'b0;
            outDataQ    <= '0;
            cipherState <= '0;
            round       <= '0;
            keyIdx      <= '0;
            kMod        <= '0;
            rconIdx     <= '0;
        end else begin
            unique case (fsmState)
                StIdle: begin
                    if (keyAccept) begin
                        keyLoaded <= 1'b0;
                        keyReadyQ <= 1'b0;
                        inReadyQ  <= 1'b0;
                        busyQ     <= 1'b1;
                        keyIdx    <= IdxW'(NK);
                        kMod      <= '0;
                        rconIdx   <= 4'd1;
                        fsmState  <= StKeyExp;
                    end else if (blockAccept) begin
                        cipherState <= in_data ^ firstKey;
                        round       <= RndW'(1);
                        keyReadyQ   <= 1'b0;
                        inReadyQ    <= 1'b0;
                        busyQ       <= 1'b1;
                        fsmState    <= StRound;
                    end
                end
                StKeyExp: begin
                    keyIdx <= keyIdx + IdxW'(1);
                    kMod   <= (kMod == 3'(NK - 1)) ? 3'd0 : kMod + 3'd1;
                    if (kMod == 3'd0) begin
                        rconIdx <= rconIdx + 4'd1;
                    end
                    if (keyIdx == IdxW'(NW - 1)) begin
                        keyLoaded <= 1'b1;
                        keyReadyQ <= 1'b1;
                        inReadyQ  <= 1'b1;
                        busyQ     <= 1'b0;
                        fsmState  <= StIdle;
                    end
                end
                StRound: begin
                    cipherState <= roundOut;
                    if (lastRound) begin
                        outDataQ  <= roundOut;
                        outValidQ <= 1'b1;
                        busyQ     <= 1'b0;
                        fsmState  <= StDone;
                    end else begin
                        round <= round + RndW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        outValidQ <= 1'b0;
                        keyReadyQ <= 1'b1;
                        inReadyQ  <= keyLoaded;
                        fsmState  <= StIdle;
                    end
                end
                default: fsmState <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Directed-vector bench for aes_iter_cipher: one instance per key size.
module tb_aes_iter_cipher;

    localparam logic [127:0] V1Key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] V1Pt   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] V1Ct   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] V2Key  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V2Pt   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V2Ct   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [191:0] K192   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] Ct192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] K256   =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] Ct256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk;
    logic         rst;
    logic [255:0] keyIn;
    logic [127:0] inData;
    logic [2:0]   keyValid, inValid, outReady;
    logic         keyReady [3];
    logic         inReady [3];
    logic         outValid [3];
    logic         busy [3];
    logic [127:0] outData [3];
    int           nTests;
    int           nFail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    aes_iter_cipher #(.KEY_BITS(128)) dut128 (
        .clk(clk), .rst(rst), .key_in(keyIn[255:128]), .key_valid(keyValid[0]),
        .key_ready(keyReady[0]), .in_data(inData), .in_valid(inValid[0]),
        .in_ready(inReady[0]), .out_data(outData[0]), .out_valid(outValid[0]),
        .out_ready(outReady[0]), .busy(busy[0])
    );

    aes_iter_cipher #(.KEY_BITS(192)) dut192 (
        .clk(clk), .rst(rst), .key_in(keyIn[255:64]), .key_valid(keyValid[1]),
        .key_ready(keyReady[1]), .in_data(inData), .in_valid(inValid[1]),
        .in_ready(inReady[1]), .out_data(outData[1]), .out_valid(outValid[1]),
        .out_ready(outReady[1]), .busy(busy[1])
    );

    aes_iter_cipher #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst(rst), .key_in(keyIn), .key_valid(keyValid[2]),
        .key_ready(keyReady[2]), .in_data(inData), .in_valid(inValid[2]),
        .in_ready(inReady[2]), .out_data(outData[2]), .out_valid(outValid[2]),
        .out_ready(outReady[2]), .busy(busy[2])
    );

    task automatic test_reset();
        rst = 1'b0;
        keyValid = '0;
        inValid = '0;
        outReady = '0;
        keyIn = '0;
        inData = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            nTests++;
            if ({keyReady[k], inReady[k], outValid[k], busy[k], outData[k]} !== {4'b1000, 128'h0})
            begin
                nFail++;
                $display("FAIL reset_values[%0d]: got kr=%b ir=%b ov=%b busy=%b od=%h, want 1 0 0 0 0",
                         k, keyReady[k], inReady[k], outValid[k], busy[k], outData[k]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Starts at a negedge with the instance idle; returns at the negedge where key_ready is back.
    task automatic load_key(input logic [1:0] k, input logic [255:0] key, input int expCycles);
        int cnt;
        int bad;
        cnt = 0;
        bad = 0;
        keyIn = key;
        keyValid[k] = 1'b1;
        @(negedge clk);
        keyValid[k] = 1'b0;
        while (keyReady[k] !== 1'b1 && cnt < 200) begin
            if (inReady[k] !== 1'b0 || busy[k] !== 1'b1) bad++;
            @(negedge clk);
            cnt++;
        end
        nTests++;
        if (cnt != expCycles) begin
            nFail++;
            $display("FAIL keyexp_cycles[%0d]: got %0d, want %0d", k, cnt, expCycles);
        end
        nTests++;
        if (bad != 0) begin
            nFail++;
            $display("FAIL keyexp_flags[%0d]: got %0d bad cycles, want 0", k, bad);
        end
    endtask

    // Called at the first negedge after the block-accept edge.
    task automatic drain_block(input logic [1:0] k, input logic [127:0] expCt, input int expLat,
                               input int hold);
        int cnt;
        int unstable;
        cnt = 0;
        unstable = 0;
        while (outValid[k] !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        nTests++;
        if (cnt != expLat) begin
            nFail++;
            $display("FAIL latency[%0d]: got %0d, want %0d", k, cnt, expLat);
        end
        nTests++;
        if (outData[k] !== expCt) begin
            nFail++;
            $display("FAIL ciphertext[%0d]: got %h, want %h", k, outData[k], expCt);
        end
        repeat (hold) begin
            @(negedge clk);
            if (outValid[k] !== 1'b1 || outData[k] !== expCt) unstable++;
        end
        if (hold > 0) begin
            nTests++;
            if (unstable != 0) begin
                nFail++;
                $display("FAIL hold_stable[%0d]: got %0d unstable cycles, want 0", k, unstable);
            end
        end
        outReady[k] = 1'b1;
        @(negedge clk);
        outReady[k] = 1'b0;
        nTests++;
        if (outValid[k] !== 1'b0 || outData[k] !== expCt || inReady[k] !== 1'b1) begin
            nFail++;
            $display("FAIL drain[%0d]: got ov=%b od=%h ir=%b, want 0 %h 1",
                     k, outValid[k], outData[k], inReady[k], expCt);
        end
    endtask

    task automatic run_block(input logic [1:0] k, input logic [127:0] pt,
                             input logic [127:0] expCt, input int expLat, input int hold);
        nTests++;
        if (inReady[k] !== 1'b1) begin
            nFail++;
            $display("FAIL block_in_ready[%0d]: got %b, want 1", k, inReady[k]);
        end
        inData = pt;
        inValid[k] = 1'b1;
        outReady[k] = 1'b0;
        @(negedge clk);
        inValid[k] = 1'b0;
        inData = '0;
        drain_block(k, expCt, expLat, hold);
    endtask

    task automatic test_no_key();
        int bad;
        int cnt;
        bad = 0;
        cnt = 0;
        inData = V1Pt;
        inValid[0] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (inReady[0] !== 1'b0 || outValid[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
        end
        nTests++;
        if (bad != 0) begin
            nFail++;
            $display("FAIL nokey_blocked: got %0d bad cycles, want 0", bad);
        end
        keyIn = {V1Key, 128'h0};
        keyValid[0] = 1'b1;
        @(negedge clk);
        keyValid[0] = 1'b0;
        while (inReady[0] !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        nTests++;
        if (cnt != 40) begin
            nFail++;
            $display("FAIL nokey_block_wait: got %0d, want 40", cnt);
        end
        @(negedge clk);
        inValid[0] = 1'b0;
        drain_block(2'd0, V1Ct, 10, 0);
    endtask

    task automatic test_vector1();
        load_key(2'd0, {V1Key, 128'h0}, 40);
        run_block(2'd0, V1Pt, V1Ct, 10, 0);
    endtask

    task automatic test_back_to_back();
        load_key(2'd0, {V2Key, 128'h0}, 40);
        run_block(2'd0, V2Pt, V2Ct, 10, 5);
        run_block(2'd0, V2Pt, V2Ct, 10, 0);
    endtask

    task automatic test_key_sizes();
        load_key(2'd1, {K192, 64'h0}, 46);
        run_block(2'd1, V2Pt, Ct192, 12, 2);
        load_key(2'd2, K256, 52);
        run_block(2'd2, V2Pt, Ct256, 14, 0);
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        load_key(2'd0, {V1Key, 128'h0}, 40);
        inData = V1Pt;
        inValid[0] = 1'b1;
        @(negedge clk);
        inValid[0] = 1'b0;
        repeat (4) @(negedge clk);
        nTests++;
        if (busy[0] !== 1'b1 || outValid[0] !== 1'b0) begin
            nFail++;
            $display("FAIL mid_block_busy: got busy=%b ov=%b, want 1 0", busy[0], outValid[0]);
        end
        rst = 1'b0;
        #1;
        nTests++;
        if ({outValid[0], inReady[0], busy[0], keyReady[0], outData[0]} !== {4'b0001, 128'h0}) begin
            nFail++;
            $display("FAIL async_reset: got ov=%b ir=%b busy=%b kr=%b od=%h, want 0 0 0 1 0",
                     outValid[0], inReady[0], busy[0], keyReady[0], outData[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        inData = V1Pt;
        inValid[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (inReady[0] !== 1'b0 || outValid[0] !== 1'b0) bad++;
        end
        inValid[0] = 1'b0;
        nTests++;
        if (bad != 0) begin
            nFail++;
            $display("FAIL key_discarded: got %0d cycles accepting, want 0", bad);
        end
        load_key(2'd0, {V1Key, 128'h0}, 40);
        run_block(2'd0, V1Pt, V1Ct, 10, 0);
    endtask

    task automatic test_rekey();
        int cnt;
        cnt = 0;
        keyIn = {V2Key, 128'h0};
        inData = V2Pt;
        keyValid[0] = 1'b1;
        inValid[0] = 1'b1;
        #1;
        nTests++;
        if (inReady[0] !== 1'b0 || keyReady[0] !== 1'b1) begin
            nFail++;
            $display("FAIL key_priority: got ir=%b kr=%b, want 0 1", inReady[0], keyReady[0]);
        end
        @(negedge clk);
        keyValid[0] = 1'b0;
        while (inReady[0] !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        nTests++;
        if (cnt != 40) begin
            nFail++;
            $display("FAIL rekey_in_ready_low: got %0d, want 40", cnt);
        end
        @(negedge clk);
        inValid[0] = 1'b0;
        drain_block(2'd0, V2Ct, 10, 0);
    endtask

    initial begin
        nTests = 0;
        nFail = 0;
        test_reset();
        test_no_key();
        test_vector1();
        test_back_to_back();
        test_key_sizes();
        test_reset_mid();
        test_rekey();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
